// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the two-requester APB master controller.
// APB_ADDR_CHECK_EN adds the ERR state used to reject out-of-range addresses.
package apb_ctrl_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NSEL   = 4;

    // Address fields: slave select decode and range check.
    localparam int SEL_LO = 12;
    localparam int SEL_HI = 13;
    localparam int CHK_LO = 14;
    localparam int CHK_HI = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
`ifdef APB_ADDR_CHECK_EN
        ACCESS = 2'd2,
        ERR    = 2'd3
`else
        ACCESS = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bundle of requester handshake, response and APB bus signals for apb_master_ctrl.
// Handshake: a requester holds req_valid with stable write/addr/wdata until it sees its
// req_ready bit high in the same cycle; that cycle is the transfer. rsp_valid is a
// one-cycle pulse to the owner, with rsp_rdata/rsp_err valid alongside it.
interface apb_master_ctrl_if
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NSEL   = DEF_NSEL
);

    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;

    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    logic [NSEL-1:0]     PSELx;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W-1:0]   PRDATA;
    logic                PSLVERR;

    state_t              dbg_state;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PRDATA, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output dbg_state
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PRDATA, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  dbg_state
    );

endinterface

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter. grant is combinational from req; last_grant only
// advances when the controller actually takes the granted request.
module apb_rr_arb (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On contention favour whoever was not served last.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset value 1 lets requester 0 win the first contention.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant <= 1'b1;
        end else if (take && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master controller: arbitrates two requesters onto a fixed two-cycle APB transfer.
// With APB_ADDR_CHECK_EN defined, addresses with nonzero check bits are rejected via ERR.
module apb_master_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NSEL   = DEF_NSEL
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_master_ctrl_if.master bus
);

    state_t            state;
    state_t            state_nxt;

    logic [1:0]        grant;
    logic              accept;
    logic              gidx;
    logic              gnt_write;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
`ifdef APB_ADDR_CHECK_EN
    logic              addr_bad;
`endif

    logic              cap_owner;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic [NSEL-1:0]   sel_onehot;

    apb_rr_arb u_arb (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .req     (bus.req_valid),
        .take    (accept),
        .grant   (grant)
    );

    // Acceptance is gated by PRESETn so req_ready stays low while reset is held.
    assign accept    = (state == IDLE) && (bus.req_valid != 2'b00) && PRESETn;
    assign gidx      = grant[1];
    assign gnt_write = gidx ? bus.req_write[1] : bus.req_write[0];
    assign gnt_addr  = gidx ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
    assign gnt_wdata = gidx ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
`ifdef APB_ADDR_CHECK_EN
    assign addr_bad  = |gnt_addr[CHK_HI:CHK_LO];
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 2'b00;
        bus.PSELx     = '0;
        bus.PENABLE   = 1'b0;
        sel_onehot    = '0;
        sel_onehot[cap_addr[SEL_HI:SEL_LO]] = 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    bus.req_ready = grant;
`ifdef APB_ADDR_CHECK_EN
                    state_nxt = addr_bad ? ERR : SETUP;
`else
                    state_nxt = SETUP;
`endif
                end
            end
            SETUP: begin
                bus.PSELx = sel_onehot;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.PSELx   = sel_onehot;
                bus.PENABLE = 1'b1;
                state_nxt   = IDLE;
            end
`ifdef APB_ADDR_CHECK_EN
            ERR: begin
                state_nxt = IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Captured request doubles as the APB address/data/direction, so those hold between transfers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cap_owner <= 1'b0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_owner <= gidx;
            cap_write <= gnt_write;
            cap_addr  <= gnt_addr;
            cap_wdata <= gnt_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;
            if (state == ACCESS) begin
                rsp_valid_q <= cap_owner ? 2'b10 : 2'b01;
                rsp_rdata_q <= cap_write ? '0 : bus.PRDATA;
                rsp_err_q   <= bus.PSLVERR;
            end
`ifdef APB_ADDR_CHECK_EN
            if (state == ERR) begin
                rsp_valid_q <= cap_owner ? 2'b10 : 2'b01;
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b1;
            end
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PWRITE    = cap_write;
    assign bus.PADDR     = cap_addr;
    assign bus.PWDATA    = cap_wdata;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed transfers, expected responses queued and checked by a monitor.
module tb_apb_master_ctrl;
    import apb_ctrl_pkg::*;

    logic PCLK;
    logic PRESETn;
    int   cyc;
    int   n_checks;
    int   n_errors;

    logic [50:0] exp_q[$];

    apb_master_ctrl_if #(.ADDR_W(16), .DATA_W(32), .NSEL(4)) bus ();

    apb_master_ctrl #(.ADDR_W(16), .DATA_W(32), .NSEL(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    // Clock and cycle counter
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    initial cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Entry layout: {response cycle[15:0], owner[1:0], err, rdata[31:0]}
    task automatic expect_rsp(input int at_cyc, input logic [1:0] owner, input logic err,
                              input logic [31:0] rdata);
        exp_q.push_back({16'(at_cyc), owner, err, rdata});
    endtask

    // Monitor / scoreboard
    always @(negedge PCLK) begin
        logic [50:0] e;
        if (bus.rsp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner", 32'(bus.rsp_valid), 32'(e[34:33]));
                check("rsp_err",   32'(bus.rsp_err),   32'(e[32]));
                check("rsp_rdata", bus.rsp_rdata,      e[31:0]);
                check("rsp_cycle", 32'(cyc[15:0]),     32'(e[50:35]));
            end
        end
    end

    // Driver: one transfer from requester idx, with APB phase checks along the way.
    task automatic do_xfer(input int idx, input logic wr, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [31:0] prd, input logic slverr,
                           input logic [3:0] exp_psel, input bit is_err);
        bit got;
        int c0;
        @(negedge PCLK);
        bus.req_valid[idx] = 1'b1;
        bus.req_write[idx] = wr;
        bus.req_addr[idx*16 +: 16]  = addr;
        bus.req_wdata[idx*32 +: 32] = wdata;
        #1;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus.req_ready[idx]) begin
                got = 1;
                break;
            end
            @(negedge PCLK);
            #1;
        end
        check("accept", 32'(got), 32'd1);
        if (!got) begin
            bus.req_valid[idx] = 1'b0;
            return;
        end
        check("req_ready_onehot", 32'(bus.req_ready), 32'(2'b01 << idx));
        c0 = cyc;
        if (is_err) expect_rsp(c0 + 2, 2'b01 << idx, 1'b1, 32'd0);
        else        expect_rsp(c0 + 3, 2'b01 << idx, slverr, wr ? 32'd0 : prd);

        @(negedge PCLK);
        bus.req_valid[idx] = 1'b0;
        bus.PRDATA  = prd;
        bus.PSLVERR = slverr;
        if (is_err) begin
            check("err_psel",    32'(bus.PSELx),   32'd0);
            check("err_penable", 32'(bus.PENABLE), 32'd0);
            @(negedge PCLK);
            check("err_psel_after", 32'(bus.PSELx), 32'd0);
            return;
        end
        check("setup_psel",    32'(bus.PSELx),   32'(exp_psel));
        check("setup_penable", 32'(bus.PENABLE), 32'd0);
        check("setup_paddr",   32'(bus.PADDR),   32'(addr));
        check("setup_pwrite",  32'(bus.PWRITE),  32'(wr));
        if (wr) check("setup_pwdata", bus.PWDATA, wdata);
        @(negedge PCLK);
        check("access_psel",    32'(bus.PSELx),   32'(exp_psel));
        check("access_penable", 32'(bus.PENABLE), 32'd1);
        check("access_paddr",   32'(bus.PADDR),   32'(addr));
        @(negedge PCLK);
        check("idle_psel",    32'(bus.PSELx),   32'd0);
        check("idle_penable", 32'(bus.PENABLE), 32'd0);
        check("idle_paddr",   32'(bus.PADDR),   32'(addr));
    endtask

    initial begin
        logic [1:0] exp_order [4];
        int  ngr;
        int  last;
        bit  got;
        n_checks = 0;
        n_errors = 0;
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset: all outputs low, even with requests pending
        PRESETn       = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_psel",      32'(bus.PSELx),     32'd0);
        check("rst_penable",   32'(bus.PENABLE),   32'd0);
        check("rst_paddr",     32'(bus.PADDR),     32'd0);
        check("rst_pwdata",    bus.PWDATA,         32'd0);
        check("rst_rdata",     bus.rsp_rdata,      32'd0);
        check("rst_state",     32'(bus.dbg_state), 32'(IDLE));
        bus.req_valid = 2'b00;
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Both requesters continuously valid: 0,1,0,1 at one grant per 3 cycles
        @(negedge PCLK);
        bus.req_valid = 2'b11;
        bus.req_write = 2'b11;
        bus.req_addr  = {16'h2000, 16'h0000};
        bus.req_wdata = {32'h1111_1111, 32'h0000_0000};
        bus.PRDATA    = 32'h0000_1234;
        ngr  = 0;
        last = 0;
        for (int t = 0; t < 30 && ngr < 4; t++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                check("rr_grant", 32'(bus.req_ready), 32'(exp_order[ngr]));
                if (ngr > 0) check("rr_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                expect_rsp(cyc + 3, exp_order[ngr], 1'b0, 32'd0);
                ngr++;
            end
            @(negedge PCLK);
        end
        bus.req_valid = 2'b00;
        check("rr_count", 32'(ngr), 32'd4);
        repeat (3) @(negedge PCLK);

        // Directed single transfers
        do_xfer(0, 1'b1, 16'h1004, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b0010, 1'b0);
        do_xfer(1, 1'b0, 16'h3010, 32'h0,         32'hA5A5_0001, 1'b1, 4'b1000, 1'b0);
        do_xfer(0, 1'b0, 16'h2FFC, 32'h0,         32'h0BAD_F00D, 1'b0, 4'b0100, 1'b0);
        bus.PSLVERR = 1'b0;
`ifdef APB_ADDR_CHECK_EN
        do_xfer(0, 1'b0, 16'h8000, 32'h0, 32'h55AA_0000, 1'b0, 4'b0000, 1'b1);
`else
        do_xfer(0, 1'b0, 16'h8000, 32'h0, 32'h55AA_0000, 1'b0, 4'b0001, 1'b0);
`endif
        repeat (2) @(negedge PCLK);

        // Reset during ACCESS of a read: aborted, no response
        bus.req_valid[1] = 1'b1;
        bus.req_write[1] = 1'b0;
        bus.req_addr[31:16] = 16'h1000;
        bus.PRDATA = 32'h7777_0000;
        #1;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus.req_ready[1]) begin
                got = 1;
                break;
            end
            @(negedge PCLK);
            #1;
        end
        check("abort_accept", 32'(got), 32'd1);
        @(negedge PCLK);
        bus.req_valid[1] = 1'b0;
        @(negedge PCLK);
        #1;
        check("abort_pre_penable", 32'(bus.PENABLE), 32'd1);
        #1;
        PRESETn = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        check("abort_psel",      32'(bus.PSELx),     32'd0);
        check("abort_penable",   32'(bus.PENABLE),   32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd0);
        check("abort_paddr",     32'(bus.PADDR),     32'd0);
        repeat (2) @(negedge PCLK);
        bus.req_valid = 2'b00;
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);

        do_xfer(1, 1'b1, 16'h0008, 32'h1234_5678, 32'h0, 1'b0, 4'b0001, 1'b0);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge PCLK);
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge PCLK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
